lab3part1_nios2_qsys_0_oci_dct_packer: RTL
==========================================

LAB3PART1_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: lab3part1_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 Parameter: DROP_CNT_W, 8, width of saturating dropped-atom counter.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: atom_valid  input  1  trace atom present this cycle; source cannot stall.
REQ-005 Port: atom  input  2  trace atom payload.
REQ-006 Port: flush  input  1  one-cycle request to emit the partial buffer.
REQ-007 Port: out_ready  input  1  downstream trace sink accepts out_word.
REQ-008 Port: dct_buffer  output  30  live fill buffer, registered.
REQ-009 Port: dct_count  output  4  atoms valid in dct_buffer, 0..15, registered.
REQ-010 Port: out_valid  output  1  out_word/out_count hold a packed word.
REQ-011 Port: out_word  output  30  packed word offered downstream.
REQ-012 Port: out_count  output  4  valid atoms in out_word, 1..15.
REQ-013 Port: drop_cnt  output  DROP_CNT_W  atoms lost while buffer full; saturates at all-ones.
REQ-014 Port: overflow  output  1  sticky; set on first dropped atom.

Function
REQ-015 Atom n (n = dct_count before accept) SHALL be written to dct_buffer[2n+1:2n]; bits above position dct_count SHALL read zero.
REQ-016 slot_free SHALL equal (!out_valid || out_ready).
REQ-017 Transfer SHALL occur when slot_free && (dct_count==15 || (flush_pending && dct_count!=0)), evaluated on registered values.
REQ-018 On transfer: out_word<=dct_buffer, out_count<=dct_count, out_valid<=1, buffer cleared, flush_pending cleared.
REQ-019 Atom accepted in the transfer cycle SHALL land in position 0 of the cleared buffer (dct_count becomes 1).
REQ-020 Atom arriving with dct_count==15 and no transfer SHALL be dropped: drop_cnt+1 (saturating), overflow<=1; buffer unchanged.
REQ-021 out_valid SHALL fall after a cycle with out_valid && out_ready and no new transfer; out_word stable while out_valid && !out_ready.
REQ-022 flush SHALL set flush_pending; flush in a transfer cycle re-arms pending for the new buffer; flush_pending with dct_count==0 SHALL clear without emitting.
REQ-023 Latency: 15th atom accepted cycle N -> out_valid at N+2 if slot free at N+1.
REQ-024 State machine on fill buffer: EMPTY (count 0), FILLING (1..14), FULL (15); EMPTY->FILLING on atom; FILLING->FULL on 15th atom; FULL->EMPTY on transfer without atom, FULL->FILLING on transfer with atom; FILLING->EMPTY/FILLING on flush transfer likewise.
REQ-025 dct_count arithmetic SHALL be 4-bit unsigned, never exceeding 15, never wrapping.

Reset
REQ-026 On reset: dct_buffer=0, dct_count=0, out_valid=0, out_word=0, out_count=0, drop_cnt=0, overflow=0, flush_pending=0, state EMPTY.
REQ-027 Reset SHALL override any simultaneous atom, flush, or transfer; a pending out_word is discarded.

Structure
REQ-028 Shared package SHALL hold: ATOM_W=2, SLOTS=15, BUF_W=30, CNT_W=4, state enum {EMPTY,FILLING,FULL}.
REQ-029 One sub-module lab3part1_nios2_qsys_0_oci_dct_outreg SHALL implement the output holding register and slot_free.
REQ-030 dct_buffer/dct_count SHALL connect directly to the existing OCI test-bench inputs of the same names.

Verification
REQ-031 15 atoms 2'b01 back-to-back, out_ready=1 -> out_word=30'h15555555, out_count=15, out_valid one cycle, dct_count returns 0.
REQ-032 3 atoms 3,2,1 then flush -> out_word=30'h0000001B, out_count=3; flush on empty buffer -> no out_valid.
REQ-033 out_ready=0, 31 atoms -> first word held stable, dct_count=15, drop_cnt=1, overflow=1.
REQ-034 255+ drops (DROP_CNT_W=8) -> drop_cnt saturates at 8'hFF.
REQ-035 Atom on transfer cycle -> dct_count=1, dct_buffer[1:0]=that atom, transferred word intact.
REQ-036 reset asserted mid-fill with out_valid=1 -> all outputs zero next cycle, following atom lands at position 0.

Source files
------------

// File: rtl/lab3part1_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared definitions for the OCI DCT trace packer.
// ATOM_W : width of one trace atom
// SLOTS  : number of atoms one packed word can hold
// BUF_W  : width of the fill buffer / packed word (ATOM_W * SLOTS)
// CNT_W  : width of the atom counters (0..SLOTS)
// fill_state_t : occupancy of the fill buffer
package lab3part1_nios2_qsys_0_oci_dct_packer_pkg;

   localparam int ATOM_W = 2;
   localparam int SLOTS  = 15;
   localparam int BUF_W  = ATOM_W * SLOTS;
   localparam int CNT_W  = 4;

   // EMPTY holds no atoms, FILLING holds 1..14, FULL holds all 15
   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } fill_state_t;

endpackage

// File: rtl/lab3part1_nios2_qsys_0_oci_dct_outreg.sv
// Output holding register for packed DCT words.
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   load             : capture load_word/load_count (only issued when slot_free)
//   load_word/count  : packed word and its atom count from the fill buffer
//   out_ready        : downstream sink accepts the offered word
//   out_valid/word/count : word currently offered downstream
//   slot_free        : register is empty or is being emptied this cycle
module lab3part1_nios2_qsys_0_oci_dct_outreg
   import lab3part1_nios2_qsys_0_oci_dct_packer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BUF_W-1:0] load_word,
   input  logic [CNT_W-1:0] load_count,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [BUF_W-1:0] out_word,
   output logic [CNT_W-1:0] out_count,
   output logic             slot_free
);

   // A new word may enter whenever the current one is absent or leaving now,
   // so back-to-back words never need a bubble.
   assign slot_free = !out_valid || out_ready;

   // Hold the offered word stable until the sink takes it; a fresh load
   // replaces it in the same cycle it is consumed. Reset discards any word.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_word  <= '0;
         out_count <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_word  <= load_word;
         out_count <= load_count;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/lab3part1_nios2_qsys_0_oci_dct_packer.sv
// OCI DCT trace packer: collects 2-bit trace atoms into a 30-bit word and
// hands full (or flushed) words to a downstream sink.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   atom_valid, atom    : incoming trace atom (source cannot stall)
//   flush               : request to emit the partially filled buffer
//   out_ready           : downstream accepts out_word
//   dct_buffer/count    : live fill buffer and number of atoms in it
//   out_valid/word/count: packed word offered downstream
//   drop_cnt            : saturating count of atoms lost while full
//   overflow            : sticky flag, set on the first lost atom
module lab3part1_nios2_qsys_0_oci_dct_packer
   import lab3part1_nios2_qsys_0_oci_dct_packer_pkg::*;
#(
   parameter int DROP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  atom_valid,
   input  logic [ATOM_W-1:0]     atom,
   input  logic                  flush,
   input  logic                  out_ready,
   output logic [BUF_W-1:0]      dct_buffer,
   output logic [CNT_W-1:0]      dct_count,
   output logic                  out_valid,
   output logic [BUF_W-1:0]      out_word,
   output logic [CNT_W-1:0]      out_count,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output logic                  overflow
);

   fill_state_t state;
   logic        flush_pending;
   logic        slot_free;
   logic        buf_full;
   logic        buf_empty;
   logic        transfer;

   assign buf_full  = (state == FULL);
   assign buf_empty = (state == EMPTY);

   // Move the buffer out when it is full, or when a flush is outstanding and
   // there is something to flush, provided the holding register can take it.
   assign transfer = slot_free && (buf_full || (flush_pending && !buf_empty));

   lab3part1_nios2_qsys_0_oci_dct_outreg u_outreg (
      .clk        (clk),
      .reset      (reset),
      .load       (transfer),
      .load_word  (dct_buffer),
      .load_count (dct_count),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_word   (out_word),
      .out_count  (out_count),
      .slot_free  (slot_free)
   );

   // Fill-buffer state machine. On a transfer the buffer restarts empty and an
   // atom arriving in the same cycle becomes atom 0 of the new buffer; a flush
   // in that cycle applies to the new buffer. Otherwise atoms append at the
   // next free slot, and an atom arriving while full is counted as dropped.
   // A pending flush on an empty buffer has nothing to emit and just expires.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= EMPTY;
         dct_buffer    <= '0;
         dct_count     <= '0;
         flush_pending <= 1'b0;
         drop_cnt      <= '0;
         overflow      <= 1'b0;
      end else if (transfer) begin
         flush_pending <= flush;
         if (atom_valid) begin
            dct_buffer <= BUF_W'(atom);
            dct_count  <= CNT_W'(1);
            state      <= FILLING;
         end else begin
            dct_buffer <= '0;
            dct_count  <= '0;
            state      <= EMPTY;
         end
      end else begin
         flush_pending <= flush || (flush_pending && !buf_empty);
         if (atom_valid) begin
            if (buf_full) begin
               overflow <= 1'b1;
               if (drop_cnt != '1) begin
                  drop_cnt <= drop_cnt + 1'b1;
               end
            end else begin
               dct_buffer[ATOM_W*int'(dct_count) +: ATOM_W] <= atom;
               dct_count <= dct_count + 1'b1;
               state     <= (dct_count == CNT_W'(SLOTS-1)) ? FULL : FILLING;
            end
         end
      end
   end

endmodule
